// File: rtl/fpnew_pkg.sv
// Shared FPnew types: IEEE status flags plus the result-ROB entry state and storage record.
package fpnew_pkg;

  localparam int unsigned FLEN = 64;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    DONE    = 2'd2
  } rob_state_e;

  // Entries are sized for the widest format; narrower results occupy the low bits.
  typedef struct packed {
    logic [FLEN-1:0] result;
    status_t         status;
  } rob_entry_t;

endpackage

// File: rtl/fpnew_result_rob.sv
// In-order retirement buffer for out-of-order opgroup results, with sticky fflags.
// Optional protocol checker enabled by defining FPNEW_ROB_CHECK_EN.
module fpnew_result_rob
  import fpnew_pkg::*;
#(
  parameter  int unsigned NumOpGroups = 4,
  parameter  int unsigned Width       = 64,
  parameter  int unsigned Depth       = 8,
  localparam int unsigned IdWidth     = $clog2(Depth)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic                                  alloc_valid_i,
  output logic                                  alloc_ready_o,
  output logic [IdWidth-1:0]                    alloc_id_o,
  input  logic [NumOpGroups-1:0]                res_valid_i,
  output logic [NumOpGroups-1:0]                res_ready_o,
  input  logic [NumOpGroups-1:0][IdWidth-1:0]   res_id_i,
  input  logic [NumOpGroups-1:0][Width-1:0]     res_result_i,
  input  status_t [NumOpGroups-1:0]             res_status_i,
  output logic                                  wb_valid_o,
  input  logic                                  wb_ready_i,
  output logic [IdWidth-1:0]                    wb_id_o,
  output logic [Width-1:0]                      wb_result_o,
  output status_t                               wb_status_o,
  output status_t                               fflags_o,
  input  logic                                  fflags_clr_i,
  output logic                                  busy_o,
  output logic                                  err_o
);

  logic [IdWidth:0]         head_q, tail_q;
  logic [IdWidth-1:0]       head_idx, tail_idx;
  rob_state_e               state_q [Depth];
  rob_state_e               state_d [Depth];
  rob_entry_t               entry_q [Depth];
  status_t                  fflags_q;
  logic                     empty, full, do_alloc, do_retire;
  logic [NumOpGroups-1:0]   wr_en;

  assign head_idx = head_q[IdWidth-1:0];
  assign tail_idx = tail_q[IdWidth-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[IdWidth] != tail_q[IdWidth]);

  assign alloc_ready_o = !full;
  assign alloc_id_o    = tail_idx;
  assign res_ready_o   = {NumOpGroups{!flush_i}};
  assign busy_o        = !empty;
  assign fflags_o      = fflags_q;

  // Full blocks allocation even if the head retires this cycle: no bypass.
  assign do_alloc  = alloc_valid_i && !full && !flush_i;
  assign wb_valid_o = (state_q[head_idx] == DONE);
  assign do_retire = wb_valid_o && wb_ready_i && !flush_i;

  assign wb_id_o     = head_idx;
  assign wb_result_o = wb_valid_o ? Width'(entry_q[head_idx].result) : '0;
  assign wb_status_o = wb_valid_o ? entry_q[head_idx].status : '0;

  // Writes to FREE or DONE entries are silently dropped.
  always_comb begin
    for (int g = 0; g < NumOpGroups; g++) begin
      wr_en[g] = res_valid_i[g] && !flush_i && (state_q[res_id_i[g]] == PENDING);
    end
  end

  // NOTE: every always_comb target gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    for (int i = 0; i < Depth; i++) state_d[i] = state_q[i];
    if (flush_i) begin
      for (int i = 0; i < Depth; i++) state_d[i] = FREE;
    end else begin
      for (int g = 0; g < NumOpGroups; g++) begin
        if (wr_en[g]) state_d[res_id_i[g]] = DONE;
      end
      if (do_retire) state_d[head_idx] = FREE;
      if (do_alloc)  state_d[tail_idx] = PENDING;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) state_q[i] <= FREE;
      head_q   <= '0;
      tail_q   <= '0;
      fflags_q <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) state_q[i] <= state_d[i];
      if (flush_i) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (do_retire) head_q <= head_q + 1'b1;
        if (do_alloc)  tail_q <= tail_q + 1'b1;
      end
      fflags_q <= (fflags_clr_i ? '0 : fflags_q) | (do_retire ? wb_status_o : '0);
    end
  end

  // NOTE: the payload array has no reset; entry state gates every read, so stale data is never visible.
  always_ff @(posedge clk_i) begin
    for (int g = 0; g < NumOpGroups; g++) begin
      if (wr_en[g]) begin
        entry_q[res_id_i[g]].result <= FLEN'(res_result_i[g]);
        entry_q[res_id_i[g]].status <= res_status_i[g];
      end
    end
  end

`ifdef FPNEW_ROB_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (alloc_valid_i && full) err_d = 1'b1;
    for (int g = 0; g < NumOpGroups; g++) begin
      if (res_valid_i[g] && !flush_i) begin
        if (state_q[res_id_i[g]] != PENDING) err_d = 1'b1;
        for (int h = g + 1; h < NumOpGroups; h++) begin
          if (res_valid_i[h] && (res_id_i[h] == res_id_i[g])) err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpnew_result_rob.sv
// Directed self-checking bench for fpnew_result_rob (Depth=8, 4 producers, 64-bit results).
module tb_fpnew_result_rob;
  import fpnew_pkg::*;

  localparam int NG = 4;
  localparam int W  = 64;
  localparam int D  = 8;
  localparam int IW = 3;

`ifdef FPNEW_ROB_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush, alloc_valid, alloc_ready;
  logic [IW-1:0]             alloc_id;
  logic [NG-1:0]             res_valid, res_ready;
  logic [NG-1:0][IW-1:0]     res_id;
  logic [NG-1:0][W-1:0]      res_result;
  status_t [NG-1:0]          res_status;
  logic                      wb_valid, wb_ready;
  logic [IW-1:0]             wb_id;
  logic [W-1:0]              wb_result;
  status_t                   wb_status, fflags;
  logic                      fflags_clr, busy, err;

  int checks = 0;
  int errors = 0;

  fpnew_result_rob #(.NumOpGroups(NG), .Width(W), .Depth(D)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
    .res_valid_i(res_valid), .res_ready_o(res_ready), .res_id_i(res_id),
    .res_result_i(res_result), .res_status_i(res_status),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_id_o(wb_id),
    .wb_result_o(wb_result), .wb_status_o(wb_status),
    .fflags_o(fflags), .fflags_clr_i(fflags_clr), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          alloc;
    logic          rv;
    logic [IW-1:0] rid;
    logic [W-1:0]  rres;
    logic [4:0]    rstat;
    logic          wbr;
    logic          e_wbv;
    logic [IW-1:0] e_wbid;
    logic [W-1:0]  e_res;
    logic [IW-1:0] e_aid;
    logic          e_busy;
    logic [4:0]    e_ff;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] res_of(input int k);
    return 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  task automatic idle();
    alloc_valid = 1'b0;
    flush       = 1'b0;
    res_valid   = '0;
    res_id      = '0;
    res_result  = '0;
    res_status  = '0;
    wb_ready    = 1'b0;
    fflags_clr  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic put(input int g, input logic [IW-1:0] id, input logic [W-1:0] r,
                     input logic [4:0] st);
    res_valid[g]  = 1'b1;
    res_id[g]     = id;
    res_result[g] = r;
    res_status[g] = status_t'(st);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alloc_ready"}, 64'(alloc_ready), 64'd1);
    check({tag, "_alloc_id"},    64'(alloc_id),    64'd0);
    check({tag, "_wb_valid"},    64'(wb_valid),    64'd0);
    check({tag, "_wb_id"},       64'(wb_id),       64'd0);
    check({tag, "_wb_result"},   wb_result,        64'd0);
    check({tag, "_wb_status"},   64'(wb_status),   64'd0);
    check({tag, "_fflags"},      64'(fflags),      64'd0);
    check({tag, "_busy"},        64'(busy),        64'd0);
    check({tag, "_err"},         64'(err),         64'd0);
    check({tag, "_res_ready"},   64'(res_ready),   64'hF);
  endtask

  initial begin
    // Out-of-order completion: alloc 0..3, results 3,1,0,2, retire 0..3.
    //         alloc rv    rid   rres       rstat     wbr   e_wbv e_wbid e_res      e_aid e_busy e_ff
    vt[0]  = '{1'b1, 1'b0, 3'd0, '0,        5'b00000, 1'b0, 1'b0, 3'd0, '0,        3'd0, 1'b0, 5'b00000};
    vt[1]  = '{1'b1, 1'b0, 3'd0, '0,        5'b00000, 1'b0, 1'b0, 3'd0, '0,        3'd1, 1'b1, 5'b00000};
    vt[2]  = '{1'b1, 1'b0, 3'd0, '0,        5'b00000, 1'b0, 1'b0, 3'd0, '0,        3'd2, 1'b1, 5'b00000};
    vt[3]  = '{1'b1, 1'b0, 3'd0, '0,        5'b00000, 1'b0, 1'b0, 3'd0, '0,        3'd3, 1'b1, 5'b00000};
    vt[4]  = '{1'b0, 1'b1, 3'd3, res_of(3), 5'b00001, 1'b0, 1'b0, 3'd0, '0,        3'd4, 1'b1, 5'b00000};
    vt[5]  = '{1'b0, 1'b1, 3'd1, res_of(1), 5'b00010, 1'b0, 1'b0, 3'd0, '0,        3'd4, 1'b1, 5'b00000};
    vt[6]  = '{1'b0, 1'b1, 3'd0, res_of(0), 5'b10000, 1'b0, 1'b0, 3'd0, '0,        3'd4, 1'b1, 5'b00000};
    vt[7]  = '{1'b0, 1'b1, 3'd2, res_of(2), 5'b00100, 1'b1, 1'b1, 3'd0, res_of(0), 3'd4, 1'b1, 5'b00000};
    vt[8]  = '{1'b0, 1'b0, 3'd0, '0,        5'b00000, 1'b1, 1'b1, 3'd1, res_of(1), 3'd4, 1'b1, 5'b10000};
    vt[9]  = '{1'b0, 1'b0, 3'd0, '0,        5'b00000, 1'b1, 1'b1, 3'd2, res_of(2), 3'd4, 1'b1, 5'b10010};
    vt[10] = '{1'b0, 1'b0, 3'd0, '0,        5'b00000, 1'b1, 1'b1, 3'd3, res_of(3), 3'd4, 1'b1, 5'b10110};
    vt[11] = '{1'b0, 1'b0, 3'd0, '0,        5'b00000, 1'b0, 1'b0, 3'd0, '0,        3'd4, 1'b0, 5'b10111};

    idle();
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      idle();
      alloc_valid = vt[i].alloc;
      wb_ready    = vt[i].wbr;
      if (vt[i].rv) put(i % NG, vt[i].rid, vt[i].rres, vt[i].rstat);
      #1;
      check($sformatf("ooo_wbv_%0d", i),  64'(wb_valid), 64'(vt[i].e_wbv));
      check($sformatf("ooo_aid_%0d", i),  64'(alloc_id), 64'(vt[i].e_aid));
      check($sformatf("ooo_busy_%0d", i), 64'(busy),     64'(vt[i].e_busy));
      check($sformatf("ooo_ff_%0d", i),   64'(fflags),   64'(vt[i].e_ff));
      if (vt[i].e_wbv) begin
        check($sformatf("ooo_wbid_%0d", i), 64'(wb_id), 64'(vt[i].e_wbid));
        check($sformatf("ooo_wbres_%0d", i), wb_result, vt[i].e_res);
      end
      tick();
    end
    check("ooo_err", 64'(err), 64'd0);

    // Fill to full, alloc blocked, retire without bypass, then wrap to ID 0.
    do_reset();
    for (int k = 0; k < D; k++) begin
      alloc_valid = 1'b1;
      #1;
      check($sformatf("fill_ready_%0d", k), 64'(alloc_ready), 64'd1);
      check($sformatf("fill_id_%0d", k),    64'(alloc_id),    64'(k));
      tick();
    end
    alloc_valid = 1'b1;
    #1;
    check("full_ready", 64'(alloc_ready), 64'd0);
    tick();
    alloc_valid = 1'b0;
    check("full_busy", 64'(busy), 64'd1);
    check("full_err", 64'(err), 64'(CHK));
    put(2, 3'd0, res_of(100), 5'b00000);
    tick();
    idle();
    wb_ready    = 1'b1;
    alloc_valid = 1'b1;
    #1;
    check("nobypass_wbv", 64'(wb_valid), 64'd1);
    check("nobypass_ready", 64'(alloc_ready), 64'd0);
    tick();
    idle();
    #1;
    check("wrap_ready", 64'(alloc_ready), 64'd1);
    check("wrap_id", 64'(alloc_id), 64'd0);
    check("wrap_busy", 64'(busy), 64'd1);

    // 20 alloc / result / retire triples walk the pointers through two wraps.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      alloc_valid = 1'b1;
      #1;
      check($sformatf("pair_aid_%0d", i), 64'(alloc_id), 64'(i % D));
      tick();
      idle();
      put(i % NG, IW'(i % D), res_of(i), 5'b00000);
      #1;
      check($sformatf("pair_early_%0d", i), 64'(wb_valid), 64'd0);
      tick();
      idle();
      wb_ready = 1'b1;
      #1;
      check($sformatf("pair_wbv_%0d", i), 64'(wb_valid), 64'd1);
      check($sformatf("pair_wbid_%0d", i), 64'(wb_id), 64'(i % D));
      check($sformatf("pair_wbres_%0d", i), wb_result, res_of(i));
      tick();
      idle();
    end
    #1;
    check("pair_busy", 64'(busy), 64'd0);

    // All four producers complete in one cycle; four back-to-back retires.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      alloc_valid = 1'b1;
      tick();
    end
    idle();
    for (int g = 0; g < NG; g++) put(g, IW'(3 - g), res_of(16 + 3 - g), 5'(1 << g));
    #1;
    check("multi_same_cycle_wbv", 64'(wb_valid), 64'd0);
    tick();
    idle();
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("multi_wbv_%0d", k), 64'(wb_valid), 64'd1);
      check($sformatf("multi_wbid_%0d", k), 64'(wb_id), 64'(k));
      check($sformatf("multi_wbres_%0d", k), wb_result, res_of(16 + k));
      check($sformatf("multi_wbst_%0d", k), 64'(wb_status), 64'(5'(1 << (3 - k))));
      tick();
    end
    idle();
    #1;
    check("multi_done_wbv", 64'(wb_valid), 64'd0);
    check("multi_fflags", 64'(fflags), 64'h0F);
    check("multi_err", 64'(err), 64'd0);

    // Writeback stall: outputs hold, fflags move only on the handshake; clear plus retire.
    alloc_valid = 1'b1;
    tick();
    idle();
    put(0, 3'd4, res_of(40), 5'b10000);
    tick();
    idle();
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("stall_wbv_%0d", c), 64'(wb_valid), 64'd1);
      check($sformatf("stall_res_%0d", c), wb_result, res_of(40));
      check($sformatf("stall_ff_%0d", c), 64'(fflags), 64'h0F);
      tick();
    end
    wb_ready   = 1'b1;
    fflags_clr = 1'b1;
    tick();
    idle();
    #1;
    check("clr_retire_ff", 64'(fflags), 64'h10);
    check("clr_retire_busy", 64'(busy), 64'd0);

    // Flush with five entries pending; a late result afterwards is dropped.
    for (int k = 0; k < 5; k++) begin
      alloc_valid = 1'b1;
      tick();
    end
    idle();
    put(0, 3'd4, res_of(77), 5'b00001);
    put(1, 3'd5, res_of(78), 5'b00001);
    flush       = 1'b1;
    alloc_valid = 1'b1;
    #1;
    check("flush_res_ready", 64'(res_ready), 64'h0);
    check("flush_busy_before", 64'(busy), 64'd1);
    tick();
    idle();
    #1;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_aid", 64'(alloc_id), 64'd0);
    check("flush_ff", 64'(fflags), 64'h10);
    check("flush_wbv", 64'(wb_valid), 64'd0);
    check("flush_err", 64'(err), 64'd0);
    put(1, 3'd2, res_of(99), 5'b01000);
    #1;
    check("late_res_ready", 64'(res_ready), 64'hF);
    tick();
    idle();
    #1;
    check("late_busy", 64'(busy), 64'd0);
    check("late_wbv", 64'(wb_valid), 64'd0);
    check("late_ff", 64'(fflags), 64'h10);
    check("late_err", 64'(err), 64'(CHK));

    // Asynchronous reset between clock edges with work in flight.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      alloc_valid = 1'b1;
      tick();
    end
    idle();
    put(3, 3'd0, res_of(5), 5'b00001);
    tick();
    idle();
    wb_ready = 1'b1;
    tick();
    idle();
    put(0, 3'd1, res_of(6), 5'b00010);
    tick();
    idle();
    #1;
    check("pre_rst_wbv", 64'(wb_valid), 64'd1);
    check("pre_rst_ff", 64'(fflags), 64'h01);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_aid", 64'(alloc_id), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
